// File: rtl/phase_a_pkg.sv
// Shared constants and FSM state type for the phase_a iteration loop.
// Defaults describe a 3072-bit operand consumed 54 bits per pass.
package phase_a_pkg;

    localparam int SIZE    = 3072;
    localparam int RADIX   = 54;
    localparam int ITER    = 57;
    localparam int TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/phase_a_loop_ctrl_if.sv
// Host command/result and phase_a a-path signals of the loop controller.
// master is the controller side, slave is its environment.
interface phase_a_loop_ctrl_if #(
    parameter int Size = 3072
);

    logic            start;
    logic [Size-1:0] a_in;
    logic            busy;
    logic            done;
    logic [Size-1:0] a_out;
    logic            err;
    logic [Size-1:0] pa_a;
    logic            pa_en;
    logic [Size-1:0] pa_new_a;
    logic            pa_en_out;

    modport master (
        input  start, a_in, pa_new_a, pa_en_out,
        output busy, done, a_out, err, pa_a, pa_en
    );

    modport slave (
        output start, a_in, pa_new_a, pa_en_out,
        input  busy, done, a_out, err, pa_a, pa_en
    );

endinterface

// File: rtl/phase_a_loop_ctrl.sv
// Iteration sequencer around phase_a: one pulse per digit, new_a fed back.
// Define PHASE_A_LOOP_TIMEOUT_EN to add the WAIT-state watchdog and err pulse.
module phase_a_loop_ctrl
    import phase_a_pkg::*;
#(
    parameter int Size    = SIZE,
    parameter int Radix   = RADIX,
    parameter int Iter    = (Size + Radix - 1) / Radix,
    parameter int Timeout = TIMEOUT
) (
    input  logic                clk,
    input  logic                rst_n,
    phase_a_loop_ctrl_if.master bus
);

    localparam int CntW = $clog2(Iter + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(Iter - 1);

    // An unusable configuration leaves this marker in the hierarchy.
    if (Iter < 1 || Timeout < 1) begin : g_bad_cfg
    end

    state_e          state_q, state_d;
    logic [Size-1:0] acc_q, acc_d;
    logic [Size-1:0] a_out_q, a_out_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            pa_en;
    logic            done;

`ifdef PHASE_A_LOOP_TIMEOUT_EN
    localparam int WdW = $clog2(Timeout + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(Timeout - 1);

    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_out_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_out_q <= a_out_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_out_d = a_out_q;
        cnt_d   = cnt_q;
        pa_en   = 1'b0;
        done    = 1'b0;
`ifdef PHASE_A_LOOP_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = bus.a_in;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                pa_en   = 1'b1;
                state_d = WAIT;
`ifdef PHASE_A_LOOP_TIMEOUT_EN
                wd_d    = '0;
`endif
            end
            WAIT: begin
                // A completion in the timeout cycle still counts as a pass.
                if (bus.pa_en_out) begin
                    acc_d = bus.pa_new_a;
                    if (cnt_q == LastCnt) begin
                        a_out_d = bus.pa_new_a;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + CntW'(1);
                        state_d = ISSUE;
                    end
                end
`ifdef PHASE_A_LOOP_TIMEOUT_EN
                else if (wd_q == WdLast) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
`endif
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = done;
    assign bus.a_out = a_out_q;
    assign bus.pa_a  = acc_q;
    assign bus.pa_en = pa_en;

endmodule

// File: tb/tb_phase_a_loop_ctrl.sv
// Directed bench: a 57-pass and a 1-pass controller, each driving a phase_a
// stub with programmable latency and new_a = a + 1.
module tb_phase_a_loop_ctrl;
    import phase_a_pkg::*;

    localparam int W = SIZE;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    phase_a_loop_ctrl_if #(.Size(W)) lb ();
    phase_a_loop_ctrl_if #(.Size(W)) sb ();

    phase_a_loop_ctrl #(.Size(W), .Iter(ITER)) u_long (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (lb.master)
    );

    phase_a_loop_ctrl #(.Size(W), .Iter(1)) u_short (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sb.master)
    );

    // phase_a stub for the long instance; latency 0 means never answer
    int         l_lat = 20;
    int         l_rem = 0;
    logic       l_pend = 1'b0;
    logic       l_eo = 1'b0;
    logic       l_spur = 1'b0;
    logic [W-1:0] l_data = '0;
    assign lb.pa_en_out = l_eo | l_spur;
    assign lb.pa_new_a  = l_spur ? W'(64'hDEAD_BEEF) : l_data;

    always @(posedge clk) begin
        l_eo <= 1'b0;
        if (!rst_n) begin
            l_pend <= 1'b0;
            l_rem  <= 0;
        end else if (lb.pa_en) begin
            l_data <= lb.pa_a + W'(1);
            if (l_lat == 1) l_eo <= 1'b1;
            else if (l_lat > 1) begin
                l_pend <= 1'b1;
                l_rem  <= l_lat - 1;
            end
        end else if (l_pend) begin
            if (l_rem == 1) begin
                l_eo   <= 1'b1;
                l_pend <= 1'b0;
            end else l_rem <= l_rem - 1;
        end
    end

    int         s_lat = 3;
    int         s_rem = 0;
    logic       s_pend = 1'b0;
    logic       s_eo = 1'b0;
    logic [W-1:0] s_data = '0;
    assign sb.pa_en_out = s_eo;
    assign sb.pa_new_a  = s_data;

    always @(posedge clk) begin
        s_eo <= 1'b0;
        if (!rst_n) begin
            s_pend <= 1'b0;
            s_rem  <= 0;
        end else if (sb.pa_en) begin
            s_data <= sb.pa_a + W'(1);
            if (s_lat == 1) s_eo <= 1'b1;
            else if (s_lat > 1) begin
                s_pend <= 1'b1;
                s_rem  <= s_lat - 1;
            end
        end else if (s_pend) begin
            if (s_rem == 1) begin
                s_eo   <= 1'b1;
                s_pend <= 1'b0;
            end else s_rem <= s_rem - 1;
        end
    end

    int   l_pulses = 0;
    int   l_viol = 0;
    int   l_dones = 0;
    int   s_pulses = 0;
    logic l_prev_en = 1'b0;
    always @(posedge clk) begin
        l_prev_en <= lb.pa_en;
        if (lb.pa_en) l_pulses <= l_pulses + 1;
        if (lb.pa_en && l_prev_en) l_viol <= l_viol + 1;
        if (lb.done) l_dones <= l_dones + 1;
        if (sb.pa_en) s_pulses <= s_pulses + 1;
    end

    task automatic chk_v(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h required %0h", tag, obs[63:0],
                   exp[63:0]);
        end
    endtask

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b required %b", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // Start the long instance at cycle 0 and wait for done (bounded).
    task automatic run_long(input logic [W-1:0] a, input bit restart,
                            input bit spur, output bit got, output int dcyc);
        got = 1'b0;
        dcyc = -1;
        lb.a_in  = a;
        lb.start = 1'b1;
        for (int k = 1; k <= 1300 && !got; k++) begin
            @(negedge clk);
            lb.start = restart && (k == 10 || k == 30);
            if (k == 10) lb.a_in = W'(999);
            l_spur = spur && (k == 1);
            if (lb.done === 1'b1) begin
                got  = 1'b1;
                dcyc = k;
            end
        end
        lb.start = 1'b0;
        l_spur   = 1'b0;
    endtask

    initial begin
        bit got;
        int dcyc;
        int p0;
        int d0;
        int errk;
        bit seen;

        lb.start = 1'b0;
        lb.a_in  = '0;
        sb.start = 1'b0;
        sb.a_in  = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk_b("rst_busy", lb.busy, 1'b0);
        chk_b("rst_done", lb.done, 1'b0);
        chk_b("rst_pa_en", lb.pa_en, 1'b0);
        chk_b("rst_err", lb.err, 1'b0);
        chk_v("rst_a_out", lb.a_out, '0);
        chk_v("rst_pa_a", lb.pa_a, '0);
        chk_b("rst_s_busy", sb.busy, 1'b0);
        chk_v("rst_s_a_out", sb.a_out, '0);

        // Iter=1, L=3: busy in cycles 1..5, done in cycle 5
        p0 = s_pulses;
        sb.a_in  = W'(5);
        sb.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            sb.start = 1'b0;
            chk_b("short_busy", sb.busy, (k >= 1 && k <= 5));
            chk_b("short_done", sb.done, (k == 5));
            if (k == 5) chk_v("short_a_out", sb.a_out, W'(6));
        end
        chk_i("short_pulses", s_pulses - p0, 1);
        chk_v("short_a_out_hold", sb.a_out, W'(6));

        // 57 passes with L=20 and ignored starts at cycles 10 and 30
        p0 = l_pulses;
        d0 = l_dones;
        run_long('0, 1'b1, 1'b0, got, dcyc);
        chk_b("long_done_seen", got, 1'b1);
        chk_i("long_done_cycle", dcyc, 1198);
        chk_v("long_a_out", lb.a_out, W'(57));
        chk_i("long_pulses", l_pulses - p0, 57);
        chk_i("long_pa_en_gap", l_viol, 0);
        @(negedge clk);
        chk_b("long_done_pulse", lb.done, 1'b0);
        chk_b("long_busy_after", lb.busy, 1'b0);
        chk_i("long_done_count", l_dones - d0, 1);
        chk_v("long_a_out_hold", lb.a_out, W'(57));

        // Spurious completion in IDLE, then in the first ISSUE cycle
        lb.a_in = W'(123);
        l_spur = 1'b1;
        @(negedge clk);
        l_spur = 1'b0;
        @(negedge clk);
        chk_b("spur_idle_busy", lb.busy, 1'b0);
        chk_v("spur_idle_acc", lb.pa_a, W'(57));
        chk_v("spur_idle_a_out", lb.a_out, W'(57));
        p0 = l_pulses;
        run_long(W'(100), 1'b0, 1'b1, got, dcyc);
        chk_b("spur_done_seen", got, 1'b1);
        chk_i("spur_done_cycle", dcyc, 1198);
        chk_v("spur_a_out", lb.a_out, W'(157));
        chk_i("spur_pulses", l_pulses - p0, 57);

        // Reset during pass 12 aborts without done
        @(negedge clk);
        p0 = l_pulses;
        lb.a_in  = '0;
        lb.start = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            lb.start = 1'b0;
            if (l_pulses - p0 == 12) got = 1'b1;
        end
        chk_b("abort_reached_pass12", got, 1'b1);
        d0 = l_dones;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_b("abort_busy", lb.busy, 1'b0);
        chk_b("abort_pa_en", lb.pa_en, 1'b0);
        chk_b("abort_done", lb.done, 1'b0);
        chk_v("abort_a_out", lb.a_out, '0);
        chk_v("abort_acc", lb.pa_a, '0);
        repeat (40) @(negedge clk);
        chk_i("abort_no_done", l_dones - d0, 0);
        chk_b("abort_still_idle", lb.busy, 1'b0);
        run_long(W'(7), 1'b0, 1'b0, got, dcyc);
        chk_b("rerun_done_seen", got, 1'b1);
        chk_i("rerun_done_cycle", dcyc, 1198);
        chk_v("rerun_a_out", lb.a_out, W'(64));

`ifdef PHASE_A_LOOP_TIMEOUT_EN
        // Stub silent: WAIT entered in cycle 2, err in cycle 66
        @(negedge clk);
        s_lat = 0;
        sb.a_in  = W'(51);
        sb.start = 1'b1;
        errk = -1;
        seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            sb.start = 1'b0;
            if (sb.done === 1'b1) seen = 1'b1;
            if (sb.err === 1'b1 && errk < 0) begin
                errk = k;
                chk_b("to_busy_drop", sb.busy, 1'b0);
            end
        end
        chk_i("to_err_cycle", errk, 66);
        chk_b("to_no_done", seen, 1'b0);
        chk_b("to_err_pulse", sb.err, 1'b0);
        chk_v("to_acc_kept", sb.pa_a, W'(51));
        chk_v("to_a_out_kept", sb.a_out, '0);

        // L=63 lands just before the limit: normal completion in cycle 65
        s_lat = 63;
        sb.a_in  = W'(51);
        sb.start = 1'b1;
        dcyc = -1;
        seen = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            sb.start = 1'b0;
            if (sb.err === 1'b1) seen = 1'b1;
            if (sb.done === 1'b1) dcyc = k;
        end
        chk_i("l63_done_cycle", dcyc, 65);
        chk_b("l63_no_err", seen, 1'b0);
        chk_v("l63_a_out", sb.a_out, W'(52));
`else
        chk_b("err_tied_low", sb.err, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
                 n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench time limit expired");
    end

endmodule
